firebird7_in_gate1_tessent_data_mux_hs: RTL and testbench



---
 rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv | 14 +
 rtl/firebird7_in_gate1_tessent_data_mux_guard_ctr.sv | 28 ++
 rtl/firebird7_in_gate1_tessent_data_mux_hs.sv | 121 ++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_hs.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and helpers for the guarded IJTAG data-override mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

  typedef enum logic [1:0] {FUNC, GUARD_IN, IJTAG, GUARD_OUT} mux_state_e;

  // Guard counter width: enough to hold GUARD_CYCLES-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned guard_cycles);
    int unsigned w;
    w = $clog2(guard_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_guard_ctr.sv
// Loadable down-counter timing the handover guard interval.
module firebird7_in_gate1_tessent_data_mux_guard_ctr #(
  parameter int unsigned CW = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          i_dec,
  output logic          zero
);

  logic [CW-1:0] r_cnt;

  // Load has priority; decrement stops at zero so the counter cannot wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_hs.sv
// Registered functional/IJTAG data mux with per-bit override mask and a
// guard interval that freezes the output on every select change.
module firebird7_in_gate1_tessent_data_mux_hs
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int unsigned WIDTH        = 19,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_select,
  input  logic [WIDTH-1:0] ijtag_bit_enable,
  input  logic [WIDTH-1:0] functional_data_in,
  input  logic [WIDTH-1:0] ijtag_data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ijtag_active,
  output logic             switching
);

  localparam int unsigned CW       = cnt_width(GUARD_CYCLES);
  localparam bit          NO_GUARD = (GUARD_CYCLES == 0);
  localparam logic [CW-1:0] LOAD_VAL = NO_GUARD ? '0 : CW'(GUARD_CYCLES - 1);

  mux_state_e       r_state;
  mux_state_e       w_state_next;
  logic             w_load;
  logic             w_dec;
  logic             w_zero;
  logic [WIDTH-1:0] w_mixed;
  logic [WIDTH-1:0] r_data;
  logic             r_active;
  logic             r_switching;

  firebird7_in_gate1_tessent_data_mux_guard_ctr #(
    .CW (CW)
  ) u_guard_ctr (
    .i_clk    (ijtag_tck),
    .i_rst_n  (ijtag_reset),
    .load     (w_load),
    .load_val (LOAD_VAL),
    .i_dec    (w_dec),
    .zero     (w_zero)
  );

  assign w_mixed = (ijtag_bit_enable & ijtag_data_in) |
                   (~ijtag_bit_enable & functional_data_in);

  // Next state plus counter load/decrement; a select change mid-guard reloads the count.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    unique case (r_state)
      FUNC: begin
        if (ijtag_select) begin
          if (NO_GUARD) begin
            w_state_next = IJTAG;
          end else begin
            w_state_next = GUARD_IN;
            w_load       = 1'b1;
          end
        end
      end
      GUARD_IN: begin
        if (!ijtag_select) begin
          w_state_next = GUARD_OUT;
          w_load       = 1'b1;
        end else if (w_zero) begin
          w_state_next = IJTAG;
        end else begin
          w_dec = 1'b1;
        end
      end
      IJTAG: begin
        if (!ijtag_select) begin
          if (NO_GUARD) begin
            w_state_next = FUNC;
          end else begin
            w_state_next = GUARD_OUT;
            w_load       = 1'b1;
          end
        end
      end
      GUARD_OUT: begin
        if (ijtag_select) begin
          w_state_next = GUARD_IN;
          w_load       = 1'b1;
        end else if (w_zero) begin
          w_state_next = FUNC;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_state_next = FUNC;
    endcase
  end

  // State, output register and status flags; data update keyed on the pre-edge state.
  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      r_state     <= FUNC;
      r_data      <= '0;
      r_active    <= 1'b0;
      r_switching <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_active    <= (w_state_next == IJTAG);
      r_switching <= (w_state_next == GUARD_IN) || (w_state_next == GUARD_OUT);
      unique case (r_state)
        FUNC:    r_data <= functional_data_in;
        IJTAG:   r_data <= w_mixed;
        default: r_data <= r_data;
      endcase
    end
  end

  assign data_out     = r_data;
  assign ijtag_active = r_active;
  assign switching    = r_switching;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_hs.sv
// Directed-vector bench for the guarded IJTAG data-override mux.
module tb_firebird7_in_gate1_tessent_data_mux_hs;
  import firebird7_in_gate1_tessent_data_mux_pkg::*;

  localparam int W = 19;

  typedef struct {
    logic         rst_n;
    logic         sel;
    logic [W-1:0] mask;
    logic [W-1:0] func;
    logic [W-1:0] ij;
    logic [W-1:0] exp_data;
    logic         exp_act;
    logic         exp_sw;
  } vec_t;

  localparam int NV = 22;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel, sel0;
  logic [W-1:0] mask, func, ij;
  logic [W-1:0] mask0, func0, ij0;
  logic [W-1:0] dout, dout0;
  logic         act, act0, sw, sw0;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  firebird7_in_gate1_tessent_data_mux_hs #(
    .WIDTH        (W),
    .GUARD_CYCLES (2)
  ) dut (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_select       (sel),
    .ijtag_bit_enable   (mask),
    .functional_data_in (func),
    .ijtag_data_in      (ij),
    .data_out           (dout),
    .ijtag_active       (act),
    .switching          (sw)
  );

  firebird7_in_gate1_tessent_data_mux_hs #(
    .WIDTH        (W),
    .GUARD_CYCLES (0)
  ) dut0 (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_select       (sel0),
    .ijtag_bit_enable   (mask0),
    .functional_data_in (func0),
    .ijtag_data_in      (ij0),
    .data_out           (dout0),
    .ijtag_active       (act0),
    .switching          (sw0)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst sel mask func ij -> data act sw
    // reset with all-ones functional data, then release
    vecs[0]  = '{1'b0, 1'b0, 19'h7FFFF, 19'h7FFFF, 19'h00000, 19'h00000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 19'h7FFFF, 19'h7FFFF, 19'h00000, 19'h00000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 19'h7FFFF, 19'h7FFFF, 19'h00000, 19'h7FFFF, 1'b0, 1'b0};
    // handover in, G=2: E0 at row 4, state IJTAG at E2, IJTAG data after E3
    vecs[3]  = '{1'b1, 1'b0, 19'h7FFFF, 19'h12345, 19'h54321, 19'h12345, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 19'h7FFFF, 19'h12345, 19'h54321, 19'h12345, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 19'h7FFFF, 19'h11111, 19'h54321, 19'h12345, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 19'h7FFFF, 19'h11111, 19'h54321, 19'h12345, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 19'h7FFFF, 19'h11111, 19'h54321, 19'h54321, 1'b1, 1'b0};
    // partial mask
    vecs[8]  = '{1'b1, 1'b1, 19'h000FF, 19'h00000, 19'h7FFFF, 19'h000FF, 1'b1, 1'b0};
    // handover out: last mixed value captured at sampling edge and held 2 cycles
    vecs[9]  = '{1'b1, 1'b0, 19'h000FF, 19'h00000, 19'h7FFFF, 19'h000FF, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 19'h000FF, 19'h2AAAA, 19'h7FFFF, 19'h000FF, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 19'h000FF, 19'h2AAAA, 19'h7FFFF, 19'h000FF, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 19'h000FF, 19'h2AAAA, 19'h7FFFF, 19'h2AAAA, 1'b0, 1'b0};
    // abort in first GUARD_IN cycle
    vecs[13] = '{1'b1, 1'b1, 19'h7FFFF, 19'h03C3C, 19'h54321, 19'h03C3C, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 19'h7FFFF, 19'h01111, 19'h54321, 19'h03C3C, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 19'h7FFFF, 19'h01111, 19'h54321, 19'h03C3C, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 19'h7FFFF, 19'h01111, 19'h54321, 19'h03C3C, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 19'h7FFFF, 19'h01111, 19'h54321, 19'h01111, 1'b0, 1'b0};
    // reset while in GUARD_OUT
    vecs[18] = '{1'b1, 1'b1, 19'h7FFFF, 19'h05555, 19'h54321, 19'h05555, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 19'h7FFFF, 19'h05555, 19'h54321, 19'h05555, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 19'h7FFFF, 19'h05555, 19'h54321, 19'h00000, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 19'h7FFFF, 19'h06666, 19'h54321, 19'h06666, 1'b0, 1'b0};

    rst_n = 1'b0;
    sel   = 1'b0;
    mask  = '0;
    func  = '0;
    ij    = '0;
    sel0  = 1'b0;
    mask0 = 19'h7FFFF;
    func0 = 19'h0AAAA;
    ij0   = 19'h05555;

    for (int i = 0; i < NV; i++) begin
      rst_n = vecs[i].rst_n;
      sel   = vecs[i].sel;
      mask  = vecs[i].mask;
      func  = vecs[i].func;
      ij    = vecs[i].ij;
      tick();
      check($sformatf("data_out[%0d]", i), 32'(dout), 32'(vecs[i].exp_data));
      check($sformatf("ijtag_active[%0d]", i), 32'(act), 32'(vecs[i].exp_act));
      check($sformatf("switching[%0d]", i), 32'(sw), 32'(vecs[i].exp_sw));
      if (!vecs[i].rst_n) begin
        check($sformatf("state_func[%0d]", i), 32'(dut.r_state), 32'(FUNC));
        check($sformatf("ctr_zero[%0d]", i), 32'(dut.u_guard_ctr.zero), 32'd1);
      end
    end

    // G=0 build: select toggles every edge, output alternates with 1-cycle latency
    for (int i = 0; i < 8; i++) begin
      sel0 = (i % 2 == 0);
      tick();
      check($sformatf("g0_data[%0d]", i), 32'(dout0), (i % 2 == 0) ? 32'h0AAAA : 32'h05555);
      check($sformatf("g0_active[%0d]", i), 32'(act0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("g0_switching[%0d]", i), 32'(sw0), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
